mcpu_soc_ledsw_arb: RTL and testbench

- Arbitrates the single LED/switch MMIO port among NREQ requesters (CPU load/store unit, debug bridge, boot/self-test sequencer).
- Accepts one request at a time via a valid/ready handshake and drives it onto the port for exactly one cycle.
- Returns registered read data to the winning requester.
- Sits between the SoC MMIO decode and the LED/switch register block.

---
 rtl/mcpu_soc_ledsw_pkg.sv | 34 +++
 rtl/mcpu_soc_rr_arb.sv | 96 +++++++++
 rtl/mcpu_soc_ledsw_arb.sv | 162 ++++++++++++++++
 tb/tb_mcpu_soc_ledsw_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_soc_ledsw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_soc_ledsw_pkg
// Purpose  : Shared constants and types for the LED/switch MMIO arbiter:
//            downstream register addresses, the idle write mask and the
//            arbiter FSM state encoding.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package mcpu_soc_ledsw_pkg;

  // Downstream register map (one address bit).
  localparam logic        LEDSW_ADDR_LED  = 1'b0;
  localparam logic        LEDSW_ADDR_SW   = 1'b1;

  // Mask driven while no transaction is in flight; never writes anything.
  localparam logic [31:0] LEDSW_IDLE_MASK = 32'h0;

  localparam int          LEDSW_DW        = 32;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } ledsw_state_e;

  // Index following idx in a ring of n entries.
  function automatic int ledsw_next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage : mcpu_soc_ledsw_pkg
`default_nettype wire

// File: rtl/mcpu_soc_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_soc_rr_arb
// Purpose  : NREQ-wide single-grant arbiter for a shared MMIO slave.
//            Default build: round-robin, the search starts at a rotating
//            pointer which moves to grant+1 after every accepted grant.
//            With MCPU_SOC_LEDSW_ARB_PRIO_EN defined: fixed priority,
//            lowest index wins and no pointer is kept.
// Ports    : clkrst_core_clk - clock
//            rst             - asynchronous active-high reset
//            req_i           - request vector
//            advance_i       - current grant was taken this cycle
//            gnt_vld_o       - some request is granted
//            gnt_idx_o       - index of the granted request
//            gnt_onehot_o    - one-hot form of the grant
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_soc_rr_arb
  import mcpu_soc_ledsw_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic            clkrst_core_clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  output logic            gnt_vld_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic [NREQ-1:0] gnt_onehot_o
);

`ifdef MCPU_SOC_LEDSW_ARB_PRIO_EN

  // Fixed priority: walk downwards so the lowest set index is written last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDW'(i);
      end
    end
  end

  // Clock, reset and advance only matter for the rotating pointer.
  logic unused_prio;
  assign unused_prio = &{1'b0, clkrst_core_clk, rst, advance_i};

`else

  logic [IDW-1:0]    rr_ptr_q;
  logic [2*NREQ-1:0] req_dbl;
  logic              unused_rot;
  int                cand;

  // Rotate the request vector so bit k is requester (rr_ptr + k) mod NREQ.
  assign req_dbl    = {req_i, req_i} >> rr_ptr_q;
  assign unused_rot = &{1'b0, req_dbl[2*NREQ-1:NREQ]};

  // Smallest rotated offset wins; walking downwards keeps the last hit.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_idx_o = '0;
    cand      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_dbl[k]) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NREQ) begin
          cand = cand - NREQ;
        end
        gnt_vld_o = 1'b1;
        gnt_idx_o = IDW'(cand);
      end
    end
  end

  always_ff @(posedge clkrst_core_clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (advance_i && gnt_vld_o) begin
      rr_ptr_q <= IDW'(ledsw_next_idx(int'(gnt_idx_o), NREQ));
    end
  end

`endif

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_onehot
      assign gnt_onehot_o[i] = gnt_vld_o && (gnt_idx_o == IDW'(i));
    end
  endgenerate

endmodule : mcpu_soc_rr_arb
`default_nettype wire

// File: rtl/mcpu_soc_ledsw_arb.sv
`default_nettype none
// ============================================================================
// Module   : mcpu_soc_ledsw_arb
// Purpose  : Arbitrates the single LED/switch MMIO port among NREQ
//            requesters. One request is accepted at a time (valid/ready),
//            driven onto the port for exactly one cycle, and answered with
//            a one-cycle response pulse carrying registered read data.
//            Handshake at t, port at t+1, response at t+2.
//            Build option MCPU_SOC_LEDSW_ARB_PRIO_EN selects fixed priority
//            (lowest index wins) instead of round-robin.
// Ports    : clkrst_core_clk - core clock
//            rst             - asynchronous active-high reset
//            req_valid       - per-requester request valid
//            req_ready       - one-hot accept, only in IDLE
//            req_addr        - per-requester word address (0 LED, 1 switch)
//            req_wdata       - write data, requester i at [32i+31:32i]
//            req_wmask       - bit write mask, all-zero means read
//            resp_valid      - one-cycle one-hot response pulse
//            resp_rdata      - read data, valid with resp_valid
//            port_addr       - downstream address (1 when idle)
//            port_data_in    - downstream write data
//            port_write_mask - downstream write mask (0 when idle)
//            port_data_out   - downstream read data (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module mcpu_soc_ledsw_arb
  import mcpu_soc_ledsw_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                 clkrst_core_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  input  logic [32*NREQ-1:0]   req_wmask,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 port_addr,
  output logic [31:0]          port_data_in,
  output logic [31:0]          port_write_mask,
  input  logic [31:0]          port_data_out
);

  ledsw_state_e    state_q;
  logic [IDW-1:0]  idx_q;
  logic            port_addr_q;
  logic [31:0]     port_data_q;
  logic [31:0]     port_mask_q;
  logic [NREQ-1:0] resp_valid_q;
  logic [31:0]     resp_rdata_q;

  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [NREQ-1:0] gnt_onehot;
  logic            ready_en;
  logic            handshake;
  logic [NREQ-1:0] resp_valid_d;

  logic            sel_addr;
  logic [31:0]     sel_wdata;
  logic [31:0]     sel_wmask;

  mcpu_soc_rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clkrst_core_clk (clkrst_core_clk),
    .rst             (rst),
    .req_i           (req_valid),
    .advance_i       (handshake),
    .gnt_vld_o       (gnt_vld),
    .gnt_idx_o       (gnt_idx),
    .gnt_onehot_o    (gnt_onehot)
  );

  // Ready is gated by reset as well: the FSM sits in IDLE while reset is
  // held, and nothing may be accepted until it is released.
  assign ready_en  = (state_q == IDLE) && !rst;
  assign req_ready = ready_en ? gnt_onehot : '0;
  assign handshake = ready_en && gnt_vld;

  // Payload of the current arbitration winner.
  always_comb begin
    sel_addr  = LEDSW_ADDR_SW;
    sel_wdata = '0;
    sel_wmask = LEDSW_IDLE_MASK;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[32*i +: 32];
        sel_wmask = req_wmask[32*i +: 32];
      end
    end
  end

  // One-hot of the held requester, loaded into resp_valid on ISSUE->RESP.
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_resp_oh
      assign resp_valid_d[i] = (idx_q == IDW'(i));
    end
  endgenerate

  // The port registers double as the holding registers: they are loaded on
  // the handshake, presented for the ISSUE cycle, and returned to the idle
  // pattern (addr=switch, mask=0) on the same edge that samples read data.
  // Reading before the write lands is what makes a write response carry
  // the pre-write register value.
  always_ff @(posedge clkrst_core_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      port_addr_q  <= LEDSW_ADDR_SW;
      port_data_q  <= '0;
      port_mask_q  <= LEDSW_IDLE_MASK;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= '0;
          if (handshake) begin
            idx_q       <= gnt_idx;
            port_addr_q <= sel_addr;
            port_data_q <= sel_wdata;
            port_mask_q <= sel_wmask;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          resp_rdata_q <= port_data_out;
          resp_valid_q <= resp_valid_d;
          port_addr_q  <= LEDSW_ADDR_SW;
          port_data_q  <= '0;
          port_mask_q  <= LEDSW_IDLE_MASK;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= '0;
          state_q      <= IDLE;
        end
        default: begin
          resp_valid_q <= '0;
          port_addr_q  <= LEDSW_ADDR_SW;
          port_data_q  <= '0;
          port_mask_q  <= LEDSW_IDLE_MASK;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign port_addr       = port_addr_q;
  assign port_data_in    = port_data_q;
  assign port_write_mask = port_mask_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;

endmodule : mcpu_soc_ledsw_arb
`default_nettype wire

// File: tb/tb_mcpu_soc_ledsw_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcpu_soc_ledsw_arb
// Purpose  : Self-checking bench for mcpu_soc_ledsw_arb with a downstream
//            LED/switch register model, a transaction-level reference model
//            and a response scoreboard. Honours MCPU_SOC_LEDSW_ARB_PRIO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcpu_soc_ledsw_arb;

  localparam int NREQ = 2;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_addr;
  logic [32*NREQ-1:0] req_wdata;
  logic [32*NREQ-1:0] req_wmask;
  logic [NREQ-1:0]    resp_valid;
  logic [31:0]        resp_rdata;
  logic               port_addr;
  logic [31:0]        port_data_in;
  logic [31:0]        port_write_mask;
  logic [31:0]        port_data_out;

  mcpu_soc_ledsw_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clkrst_core_clk (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_wmask       (req_wmask),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .port_addr       (port_addr),
    .port_data_in    (port_data_in),
    .port_write_mask (port_write_mask),
    .port_data_out   (port_data_out)
  );

  // Downstream LED/switch block: register 0 updated every cycle addr==0.
  logic [31:0] led_reg = 32'h0;
  logic [9:0]  sw  = 10'h0;
  logic [3:0]  btn = 4'h0;
  logic [31:0] sw_word;
  assign sw_word       = {6'b0, sw, 12'b0, btn};
  assign port_data_out = port_addr ? sw_word : led_reg;
  always @(posedge clk)
    if (port_addr == 1'b0)
      led_reg <= (led_reg & ~port_write_mask) | (port_data_in & port_write_mask);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester-side pending transactions.
  bit          pend   [NREQ];
  logic        p_addr [NREQ];
  logic [31:0] p_wdata[NREQ];
  logic [31:0] p_wmask[NREQ];

  // Reference model state.
  int          rr    = 0;
  int          phase = 0;   // 0 idle, 1 port cycle, 2 response cycle
  logic        h_addr;
  logic [31:0] h_wdata, h_wmask;
  logic [31:0] ref_led = 32'h0;
  logic [31:0] ref_led_prev = 32'h0;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    int          due;
  } exp_t;
  exp_t sb[$];
  int   dut_grants[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int pick();
`ifdef MCPU_SOC_LEDSW_ARB_PRIO_EN
    for (int i = 0; i < NREQ; i++)
      if (pend[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (rr + k) % NREQ;
      if (pend[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic bit pend_any();
    for (int i = 0; i < NREQ; i++)
      if (pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic arm(input int i, input logic a, input logic [31:0] d, input logic [31:0] m);
    pend[i]    = 1'b1;
    p_addr[i]  = a;
    p_wdata[i] = d;
    p_wmask[i] = m;
  endtask

  // One clock cycle: drive requests, check ready/port, advance the model.
  task automatic step();
    int              win;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]          = pend[i];
      req_addr[i]           = p_addr[i];
      req_wdata[32*i +: 32] = p_wdata[i];
      req_wmask[32*i +: 32] = p_wmask[i];
    end
    #1;
    exp_rdy = '0;
    win     = -1;
    if (phase == 0) begin
      win = pick();
      if (win >= 0) exp_rdy = oh(win);
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) dut_grants.push_back(i);
    if (phase == 1) begin
      chk("port_addr", 32'(port_addr), 32'(h_addr));
      chk("port_data_in", port_data_in, h_wdata);
      chk("port_write_mask", port_write_mask, h_wmask);
    end else begin
      chk("port_addr_idle", 32'(port_addr), 32'd1);
      chk("port_mask_idle", port_write_mask, 32'h0);
    end
    case (phase)
      0: if (win >= 0) begin
        h_addr  = p_addr[win];
        h_wdata = p_wdata[win];
        h_wmask = p_wmask[win];
        e.idx   = win;
        e.rdata = h_addr ? sw_word : ref_led;
        e.due   = cyc + 2;
        sb.push_back(e);
        ref_led_prev = ref_led;
        if (h_addr == 1'b0) ref_led = (ref_led & ~h_wmask) | (h_wdata & h_wmask);
        rr        = (win + 1) % NREQ;
        pend[win] = 1'b0;
        phase     = 1;
      end
      1: phase = 2;
      default: phase = 0;
    endcase
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((pend_any() || phase != 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_bound", 32'(n < maxc), 32'd1);
  endtask

  // Response monitor: independent of the driver, pops on each response.
  initial begin
    logic [NREQ-1:0] exp_rv;
    forever begin
      @(posedge clk);
      #1;
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].due == cyc) exp_rv = oh(sb[0].idx);
      chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
      if (exp_rv != '0) begin
        chk("resp_rdata", resp_rdata, sb[0].rdata);
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].due < cyc) begin
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    int exp_order[4];
    logic [31:0] led_before;
`ifdef MCPU_SOC_LEDSW_ARB_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; p_addr[i] = 1'b1; p_wdata[i] = '0; p_wmask[i] = '0;
    end
    req_valid = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;

    // Reset held with both requesters valid.
    arm(0, 1'b1, 32'h0, 32'h0);
    arm(1, 1'b1, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    req_valid = 2'b11;
    req_addr  = 2'b11;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_port_mask", port_write_mask, 32'h0);
    chk("rst_port_addr", 32'(port_addr), 32'd1);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    req_valid = '0;
    rst = 1'b0;
    drain(20);

    // Round-robin / priority order with both requesters continuously valid.
    dut_grants.delete();
    for (int n = 0; n < 40 && dut_grants.size() < 4; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i]) arm(i, 1'b1, $urandom, 32'h0);
      step();
    end
    chk("order_count", 32'(dut_grants.size() >= 4), 32'd1);
    if (dut_grants.size() >= 4)
      for (int k = 0; k < 4; k++) chk("grant_order", 32'(dut_grants[k]), 32'(exp_order[k]));
    drain(40);

    // Single full write to LED then read back.
    arm(0, 1'b0, 32'h0003_FFFF, 32'hFFFF_FFFF);
    drain(20);
    chk("led_after_write", led_reg, 32'h0003_FFFF);
    arm(0, 1'b0, 32'hDEAD_BEEF, 32'h0);
    drain(20);

    // Switch/button read by requester 1.
    sw  = 10'h2A5;
    btn = 4'h9;
    arm(1, 1'b1, $urandom, 32'h0);
    drain(20);

    // Partial mask write.
    arm(0, 1'b0, 32'h0000_00FF, 32'hFFFF_FFFF);
    drain(20);
    arm(0, 1'b0, 32'h0000_1200, 32'h0000_FF00);
    drain(20);
    chk("led_partial", led_reg, 32'h0000_12FF);
    arm(1, 1'b0, 32'h0, 32'h0);
    drain(20);

    // Reset in the port cycle of a write: dropped, no response, port idle.
    led_before = led_reg;
    arm(0, 1'b0, 32'hA5A5_5A5A, 32'hFFFF_FFFF);
    for (int n = 0; n < 10 && phase == 0; n++) step();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_port_mask", port_write_mask, 32'h0);
    chk("midrst_port_addr", 32'(port_addr), 32'd1);
    chk("midrst_resp_valid", 32'(resp_valid), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    ref_led = ref_led_prev;
    rr      = 0;
    phase   = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_led_kept", led_reg, led_before);
    arm(0, 1'b0, 32'h0, 32'h0);
    drain(20);

    // Randomized traffic with withdrawals and changing switch inputs.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          logic [31:0] m;
          case ($urandom_range(0, 3))
            0:       m = 32'h0;
            1:       m = 32'hFFFF_FFFF;
            default: m = $urandom;
          endcase
          arm(i, 1'($urandom_range(0, 1)), $urandom, m);
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      if (phase == 0 && $urandom_range(0, 7) == 0) begin
        sw  = 10'($urandom);
        btn = 4'($urandom);
      end
      step();
    end
    drain(40);
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mcpu_soc_ledsw_arb
`default_nettype wire
